// File: rtl/mem_store_buffer_if.sv
// Load/store request bus between the pipeline's load/store stage and the store buffer.
// Master drives the request; slave returns completion (ready) and load data.
interface mem_store_buffer_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        req_ready;
  logic [31:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_rdata
  );
endinterface

// File: rtl/mem_store_buffer.sv
// Posted-store ring buffer retiring byte-enabled stores by read-modify-write; loads bypass unless a buffered store hits their word.
// Optional STORE_FWD_EN: a conflicting load whose youngest matching entry is a full-word store completes from the buffer.
module mem_store_buffer #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  mem_store_buffer_if.slave          bus,
  output logic [ADDR_W-1:0]          o_mem_addr,
  output logic [DATA_W-1:0]          o_mem_wdata,
  output logic                       o_mem_read_en,
  output logic                       o_mem_write_en,
  input  logic [DATA_W-1:0]          i_mem_rdata,
  output logic                       o_buf_empty,
  output logic [$clog2(DEPTH):0]     o_buf_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [3:0]        r_be   [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic [ADDR_W-1:0] w_ld_word;
  logic [PTR_W-1:0]  w_idx;
  logic              w_conflict;
  logic              w_fwd_ok;
  logic [DATA_W-1:0] w_fwd_data;
  logic              w_load;
  logic              w_store;
  logic              w_load_mem;
  logic              w_load_done;
  logic              w_drain;
  logic              w_push;
  logic              w_unused_addr;

  assign w_ld_word     = bus.req_addr[ADDR_W+1:2];
  assign w_unused_addr = ^{bus.req_addr[31:ADDR_W+2], bus.req_addr[1:0]};

  // Scan from head so the youngest matching entry is the last one seen.
  always_comb begin
    w_idx      = r_head;
    w_conflict = 1'b0;
    w_fwd_ok   = 1'b0;
    w_fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + PTR_W'(k);
      if (r_vld[w_idx] && (r_addr[w_idx] == w_ld_word)) begin
        w_conflict = 1'b1;
`ifdef STORE_FWD_EN
        w_fwd_ok   = (r_be[w_idx] == 4'hF);
        w_fwd_data = r_data[w_idx];
`endif
      end
    end
  end

  assign w_load      = bus.req_valid & ~bus.req_we;
  assign w_store     = bus.req_valid & bus.req_we & (|bus.req_be);
  assign w_load_mem  = w_load & ~w_conflict;
  assign w_load_done = w_load & (~w_conflict | w_fwd_ok);
  assign w_drain     = ~reset & ~w_load_mem & (r_count != '0);
  assign w_push      = ~reset & w_store;

  assign bus.req_ready = ~reset & (~w_load | w_load_done);
  assign bus.rsp_rdata = (~reset & w_load_done) ? (w_load_mem ? i_mem_rdata : w_fwd_data) : '0;

  assign o_mem_addr     = w_load_mem ? w_ld_word : r_addr[r_head];
  assign o_mem_read_en  = ~reset & (w_load_mem | w_drain);
  assign o_mem_write_en = w_drain;
  assign o_buf_empty    = reset | (r_count == '0);
  assign o_buf_count    = r_count;

  always_comb begin
    o_mem_wdata = i_mem_rdata;
    for (int i = 0; i < 4; i++) begin
      if (r_be[r_head][i]) o_mem_wdata[8*i +: 8] = r_data[r_head][8*i +: 8];
    end
  end

  // Pop clears valid before push sets it, so a full-buffer push into the head slot survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_drain) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PTR_W'(1);
      end
      if (w_push) begin
        r_vld[r_tail]  <= 1'b1;
        r_addr[r_tail] <= w_ld_word;
        r_data[r_tail] <= bus.req_wdata;
        r_be[r_tail]   <= bus.req_be;
        r_tail         <= r_tail + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_drain);
    end
  end

endmodule
